// File: rtl/uart_apb_master.sv
// UART command-frame parser driving one APB transfer per frame and returning a response byte stream.
// Optional ACCESS watchdog enabled by defining APB_TIMEOUT_EN (responds 0x54 after TIMEOUT_CYCLES).
module uart_apb_master #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, SETUP, ACCESS, RESP} state_t;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK   = 8'h4B;
  localparam logic [7:0] RSP_ERR   = 8'h45;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : gBadTimeout
    $error("TIMEOUT_CYCLES must be within 2..255");
  end

  state_t      state_q, state_d;
  logic [31:0] paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic        pwrite_q, pwrite_d;
  logic        psel_q, penable_q, txValid_q;
  logic [31:0] respBuf_q, respBuf_d;
  logic [1:0]  respCnt_q, respCnt_d;
  logic [1:0]  dataCnt_q, dataCnt_d;
  logic        rxFire, txFire;

`ifdef APB_TIMEOUT_EN
  localparam logic [7:0] RSP_TMO  = 8'h54;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] tmoCnt_q, tmoCnt_d;
`endif

  assign rxFire = rx_valid && rx_ready;
  assign txFire = txValid_q && tx_ready;

  always_comb begin
    state_d   = state_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pwrite_d  = pwrite_q;
    respBuf_d = respBuf_q;
    respCnt_d = respCnt_q;
    dataCnt_d = dataCnt_q;
`ifdef APB_TIMEOUT_EN
    tmoCnt_d  = tmoCnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (rxFire) begin
          if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
            pwrite_d = (rx_data == CMD_WRITE);
            pwdata_d = '0;
            state_d  = GET_ADDR;
          end else begin
            respBuf_d = {24'h0, RSP_ERR};
            respCnt_d = 2'd0;
            state_d   = RESP;
          end
        end
      end
      GET_ADDR: begin
        if (rxFire) begin
          paddr_d   = {24'h0, rx_data};
          dataCnt_d = 2'd0;
          state_d   = pwrite_q ? GET_DATA : SETUP;
        end
      end
      GET_DATA: begin
        // Bytes arrive LSB first, so shift each new byte in from the top.
        if (rxFire) begin
          pwdata_d  = {rx_data, pwdata_q[31:8]};
          dataCnt_d = dataCnt_q + 2'd1;
          if (dataCnt_q == 2'd3) state_d = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
`ifdef APB_TIMEOUT_EN
        tmoCnt_d = '0;
`endif
      end
      ACCESS: begin
        if (PREADY) begin
          respBuf_d = pwrite_q ? {24'h0, RSP_ACK} : PRDATA;
          respCnt_d = pwrite_q ? 2'd0 : 2'd3;
          state_d   = RESP;
        end
`ifdef APB_TIMEOUT_EN
        else if (tmoCnt_q == TMO_LAST) begin
          respBuf_d = {24'h0, RSP_TMO};
          respCnt_d = 2'd0;
          state_d   = RESP;
        end else begin
          tmoCnt_d = tmoCnt_q + 8'd1;
        end
`endif
      end
      RESP: begin
        if (txFire) begin
          if (respCnt_q == 2'd0) begin
            state_d = IDLE;
          end else begin
            respBuf_d = {8'h0, respBuf_q[31:8]};
            respCnt_d = respCnt_q - 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus strobes and tx_valid are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      txValid_q <= 1'b0;
      respBuf_q <= '0;
      respCnt_q <= '0;
      dataCnt_q <= '0;
`ifdef APB_TIMEOUT_EN
      tmoCnt_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      psel_q    <= (state_d == SETUP) || (state_d == ACCESS);
      penable_q <= (state_d == ACCESS);
      txValid_q <= (state_d == RESP);
      respBuf_q <= respBuf_d;
      respCnt_q <= respCnt_d;
      dataCnt_q <= dataCnt_d;
`ifdef APB_TIMEOUT_EN
      tmoCnt_q  <= tmoCnt_d;
`endif
    end
  end

  assign rx_ready = (state_q == IDLE) || (state_q == GET_ADDR) || (state_q == GET_DATA);
  assign busy     = (state_q != IDLE);
  assign tx_data  = respBuf_q[7:0];
  assign tx_valid = txValid_q;
  assign PADDR    = paddr_q;
  assign PWDATA   = pwdata_q;
  assign PWRITE   = pwrite_q;
  assign PSEL     = psel_q;
  assign PENABLE  = penable_q;

endmodule

// File: tb/tb_uart_apb_master.sv
// Self-checking bench for uart_apb_master: frame-level model plus a register-slave stand-in.
// Covers the APB_TIMEOUT_EN watchdog too when that macro is defined.
module tb_uart_apb_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PSEL, PENABLE, PWRITE;
  logic        PREADY;
  logic        busy;

  int checks = 0;
  int passes = 0;
  int apbCount = 0;
  int pselCycles = 0;

  logic [31:0] slaveMem [256] = '{default: '0};
  logic [31:0] modelMem [256] = '{default: '0};
  logic        slaveMute = 1'b0;
  logic [64:0] apbQ [$];
  logic [7:0]  txQ [$];
  logic [7:0]  txLog [$];
  logic [64:0] apbExp;
  logic [7:0]  txExp;

  always #5 clk = ~clk;

  uart_apb_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PRDATA(PRDATA), .PREADY(PREADY), .busy(busy)
  );

  // Register-slave stand-in: PREADY one cycle after PSEL&&PENABLE, write committed on completion.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      PREADY <= 1'b0;
    end else begin
      PREADY <= PSEL && PENABLE && !PREADY && !slaveMute;
      if (PSEL && PENABLE && PREADY && PWRITE) slaveMem[PADDR[7:0]] <= PWDATA;
    end
  end
  assign PRDATA = slaveMem[PADDR[7:0]];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic failNote(input string name);
    checks++;
    $display("[TB] FAIL %s: got nothing, expected completion", name);
  endtask

  // Compare process: every completed APB transfer and every accepted tx byte against the model queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (PSEL) pselCycles++;
      if (PSEL && PENABLE && PREADY) begin
        apbCount++;
        if (apbQ.size() == 0) failNote("unexpected apb transfer");
        else begin
          apbExp = apbQ.pop_front();
          check("apb write/addr", {31'h0, PWRITE, PADDR}, {31'h0, apbExp[64:32]});
          check("apb wdata", {32'h0, PWDATA}, {32'h0, apbExp[31:0]});
        end
      end
      if (tx_valid && tx_ready) begin
        txLog.push_back(tx_data);
        if (txQ.size() == 0) failNote("unexpected tx byte");
        else begin
          txExp = txQ.pop_front();
          check("tx byte", {56'h0, tx_data}, {56'h0, txExp});
        end
      end
      if (PSEL || tx_valid) check("rx_ready low while busy", {63'h0, rx_ready}, 64'h0);
    end
  end

  task automatic sendByte(input logic [7:0] b);
    bit taken = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 100 && !taken; i++) begin
      @(negedge clk);
      taken = rx_ready;
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
    if (!taken) failNote("rx byte accept");
  endtask

  task automatic doWrite(input logic [7:0] addr, input logic [31:0] data);
    apbQ.push_back({1'b1, 24'h0, addr, data});
    modelMem[addr] = data;
    txQ.push_back(8'h4B);
    sendByte(8'h57);
    sendByte(addr);
    for (int i = 0; i < 4; i++) sendByte(data[8*i +: 8]);
  endtask

  task automatic doRead(input logic [7:0] addr);
    logic [31:0] word;
    word = modelMem[addr];
    apbQ.push_back({1'b0, 24'h0, addr, 32'h0});
    for (int i = 0; i < 4; i++) txQ.push_back(word[8*i +: 8]);
    sendByte(8'h52);
    sendByte(addr);
  endtask

  task automatic doInvalid(input logic [7:0] b);
    txQ.push_back(8'h45);
    sendByte(b);
  endtask

  task automatic waitIdle(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      done = !busy && txQ.size() == 0 && apbQ.size() == 0;
    end
    @(posedge clk);
    #1;
    if (!done) failNote(name);
  endtask

  task automatic checkLastBytes(input string name, input logic [31:0] word);
    int n;
    n = txLog.size();
    if (n < 4) failNote(name);
    else for (int i = 0; i < 4; i++) check(name, {56'h0, txLog[n-4+i]}, {56'h0, word[8*i +: 8]});
  endtask

  initial begin
    int snapPsel;
    int cnt;
    bit seen;

    // Reset values while reset is held.
    repeat (3) @(posedge clk);
    #1;
    check("reset PSEL", {63'h0, PSEL}, 64'h0);
    check("reset PENABLE", {63'h0, PENABLE}, 64'h0);
    check("reset PWRITE", {63'h0, PWRITE}, 64'h0);
    check("reset PADDR", {32'h0, PADDR}, 64'h0);
    check("reset PWDATA", {32'h0, PWDATA}, 64'h0);
    check("reset tx_valid", {63'h0, tx_valid}, 64'h0);
    check("reset tx_data", {56'h0, tx_data}, 64'h0);
    check("reset busy", {63'h0, busy}, 64'h0);
    check("reset rx_ready", {63'h0, rx_ready}, 64'h1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Write frame with cycle-exact bus timing after the last byte.
    doWrite(8'h02, 32'hDEADBEEF);
    @(negedge clk);
    check("setup PSEL/PENABLE", {62'h0, PSEL, PENABLE}, 64'h2);
    check("setup PADDR", {32'h0, PADDR}, 64'h2);
    check("setup PWRITE", {63'h0, PWRITE}, 64'h1);
    check("setup PWDATA", {32'h0, PWDATA}, 64'hDEADBEEF);
    @(negedge clk);
    check("access1 PSEL/PENABLE", {62'h0, PSEL, PENABLE}, 64'h3);
    @(negedge clk);
    check("access2 PSEL/PENABLE", {62'h0, PSEL, PENABLE}, 64'h3);
    check("access2 tx_valid", {63'h0, tx_valid}, 64'h0);
    @(negedge clk);
    check("resp PSEL/PENABLE", {62'h0, PSEL, PENABLE}, 64'h0);
    check("resp tx_valid", {63'h0, tx_valid}, 64'h1);
    check("resp tx_data", {56'h0, tx_data}, 64'h4B);
    @(posedge clk);
    #1;
    waitIdle("write idle");

    // Read-back of the written word.
    doRead(8'h02);
    waitIdle("readback idle");
    checkLastBytes("readback byte", 32'hDEADBEEF);

    // Invalid command: no APB activity, error byte, then a normal read.
    snapPsel = pselCycles;
    doInvalid(8'h33);
    waitIdle("invalid idle");
    check("invalid no PSEL", 64'(pselCycles), 64'(snapPsel));
    if (txLog.size() == 0) failNote("invalid response");
    else check("invalid response", {56'h0, txLog[txLog.size()-1]}, 64'h45);
    doRead(8'h00);
    waitIdle("read0 idle");
    checkLastBytes("read0 byte", 32'h0);

    // Backpressure on the read response.
    tx_ready = 1'b0;
    doRead(8'h02);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = tx_valid;
    end
    if (!seen) failNote("backpressure tx_valid");
    for (int i = 0; i < 10; i++) begin
      check("backpressure tx_valid", {63'h0, tx_valid}, 64'h1);
      check("backpressure tx_data", {56'h0, tx_data}, 64'hEF);
      check("backpressure rx_ready", {63'h0, rx_ready}, 64'h0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    tx_ready = 1'b1;
    waitIdle("backpressure idle");
    checkLastBytes("backpressure byte", 32'hDEADBEEF);

    // Reset during ACCESS discards the frame; next frame must work.
    sendByte(8'h57);
    sendByte(8'h01);
    sendByte(8'hAA);
    sendByte(8'hBB);
    sendByte(8'hCC);
    sendByte(8'hDD);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = PENABLE;
    end
    if (!seen) failNote("reach ACCESS");
    #2;
    rst = 1'b1;
    #1;
    check("async reset PSEL/PENABLE", {62'h0, PSEL, PENABLE}, 64'h0);
    check("async reset tx_valid", {63'h0, tx_valid}, 64'h0);
    check("async reset busy", {63'h0, busy}, 64'h0);
    check("async reset rx_ready", {63'h0, rx_ready}, 64'h1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    doWrite(8'h01, 32'h12345678);
    waitIdle("post-reset write idle");
    doRead(8'h01);
    waitIdle("post-reset read idle");
    checkLastBytes("post-reset byte", 32'h12345678);

`ifdef APB_TIMEOUT_EN
    // Silent slave: ACCESS lasts exactly TIMEOUT_CYCLES, then 0x54.
    slaveMute = 1'b1;
    txQ.push_back(8'h54);
    sendByte(8'h52);
    sendByte(8'h01);
    cnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (PENABLE) cnt++;
      else if (cnt > 0) seen = 1'b1;
    end
    if (!seen) failNote("timeout exit");
    check("timeout ACCESS cycles", 64'(cnt), 64'd16);
    check("timeout PSEL", {63'h0, PSEL}, 64'h0);
    check("timeout tx_data", {56'h0, tx_data}, 64'h54);
    @(posedge clk);
    #1;
    waitIdle("timeout idle");
    slaveMute = 1'b0;
`endif

    check("tx queue drained", 64'(txQ.size()), 64'h0);
    check("apb queue drained", 64'(apbQ.size()), 64'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
